// File: rtl/n64adv_vpll_sequencer.sv
// Video PLL sequencer. It test-enables the PLL and waits for a stable lock,
// then switches the output mux to the 75MHz Tx clock. If lock is lost it falls
// back to VCLK and retries. After a bounded number of failed attempts it stays
// in FAIL until the request drops. Runs on the 4MHz controller clock.
module n64adv_vpll_sequencer #(
  parameter int LOCK_TIMEOUT = 4000,
  parameter int LOCK_STABLE  = 256,
  parameter int SETTLE       = 16,
  parameter int RETRIES      = 3
) (
  input  logic       CLK_4M,
  input  logic       RST,
  input  logic       VPLL_REQ,
  input  logic       CFG_SEL_LSB,
  input  logic       VCLK_PLL_LOCKED,
  output logic [1:0] MANAGE_VPLL,
  output logic [1:0] VCLK_select,
  output logic       VPLL_ACTIVE,
  output logic       VPLL_FAIL,
  output logic [2:0] STATE
);

  localparam int CMAX0 = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int CMAX  = (CMAX0 > SETTLE) ? CMAX0 : SETTLE;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW    = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [RW-1:0] RC_MAX   = RW'(RETRIES);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_TEST    = 3'd1,
    S_STABLE  = 3'd2,
    S_ENGAGE  = 3'd3,
    S_RUN     = 3'd4,
    S_RELEASE = 3'd5,
    S_RETRY   = 3'd6,
    S_FAIL    = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rc;
  logic          lk_meta, lk;
  logic [1:0]    manage_d;
  logic          sel1_d;

  // Two-flop synchronizer. The PLL lock is asynchronous to CLK_4M.
  always_ff @(posedge CLK_4M or posedge RST) begin
    if (RST) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= VCLK_PLL_LOCKED;
      lk      <= lk_meta;
    end
  end

  // State register. cnt restarts on every transition. rc counts entries into
  // RETRY and saturates at RETRIES.
  always_ff @(posedge CLK_4M or posedge RST) begin
    if (RST) begin
      state <= S_OFF;
      cnt   <= '0;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if ((state == S_ENGAGE && state_nxt == S_RUN) ||
          (state == S_FAIL && state_nxt == S_OFF))
        rc <= '0;
      else if (state_nxt == S_RETRY && state != S_RETRY && rc < RC_MAX)
        rc <= rc + 1'b1;
    end
  end

  // Next-state logic. Within a state, the request is checked first, then lock,
  // then the counter. RELEASE and RETRY always finish their settle window.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_OFF:     if (VPLL_REQ) state_nxt = S_TEST;
      S_TEST:    if (!VPLL_REQ)            state_nxt = S_OFF;
                 else if (lk)              state_nxt = S_STABLE;
                 else if (cnt == TO_LAST)  state_nxt = S_RETRY;
      S_STABLE:  if (!VPLL_REQ)            state_nxt = S_OFF;
                 else if (!lk)             state_nxt = S_TEST;
                 else if (cnt == ST_LAST)  state_nxt = S_ENGAGE;
      S_ENGAGE:  if (!VPLL_REQ)            state_nxt = S_OFF;
                 else if (!lk)             state_nxt = S_RETRY;
                 else if (cnt == SET_LAST) state_nxt = S_RUN;
      S_RUN:     if (!VPLL_REQ)            state_nxt = S_RELEASE;
                 else if (!lk)             state_nxt = S_RETRY;
      S_RELEASE: if (cnt == SET_LAST)      state_nxt = S_OFF;
      S_RETRY:   if (cnt == SET_LAST) begin
                   if (rc >= RC_MAX)       state_nxt = S_FAIL;
                   else if (VPLL_REQ)      state_nxt = S_TEST;
                   else                    state_nxt = S_OFF;
                 end
      S_FAIL:    if (!VPLL_REQ)            state_nxt = S_OFF;
      default:                             state_nxt = S_OFF;
    endcase
  end

  // Output decode of the next state. The outputs are registered alongside the
  // state, so select drops on the same edge that leaves RUN.
  always_comb begin
    manage_d = 2'b00;
    sel1_d   = 1'b0;
    unique case (state_nxt)
      S_TEST, S_STABLE:    manage_d = 2'b01;
      S_ENGAGE, S_RELEASE: manage_d = 2'b10;
      S_RUN: begin
        manage_d = 2'b10;
        sel1_d   = 1'b1;
      end
      default:             manage_d = 2'b00;
    endcase
  end

  // Output registers. A reset pulls every output low immediately, which also
  // turns off the PLL.
  always_ff @(posedge CLK_4M or posedge RST) begin
    if (RST) begin
      MANAGE_VPLL <= 2'b00;
      VCLK_select <= 2'b00;
      VPLL_ACTIVE <= 1'b0;
      VPLL_FAIL   <= 1'b0;
    end else begin
      MANAGE_VPLL <= manage_d;
      VCLK_select <= {sel1_d, CFG_SEL_LSB};
      VPLL_ACTIVE <= (state_nxt == S_RUN);
      VPLL_FAIL   <= (state_nxt == S_FAIL);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_n64adv_vpll_sequencer.sv
// Directed bench for n64adv_vpll_sequencer, using small timing parameters.
// obs packs {STATE, MANAGE_VPLL, VCLK_select, VPLL_ACTIVE, VPLL_FAIL}.
module tb_n64adv_vpll_sequencer;

  logic       clk = 1'b0;
  logic       rst, req, cfg, lock;
  logic [1:0] manage, vsel;
  logic       active, fail;
  logic [2:0] st;
  logic [8:0] obs, exp;
  int         n_cmp = 0;
  int         n_err = 0;

  assign obs = {st, manage, vsel, active, fail};

  always #5 clk = ~clk;

  n64adv_vpll_sequencer #(
    .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .SETTLE(4), .RETRIES(2)
  ) dut (
    .CLK_4M(clk), .RST(rst), .VPLL_REQ(req), .CFG_SEL_LSB(cfg),
    .VCLK_PLL_LOCKED(lock), .MANAGE_VPLL(manage), .VCLK_select(vsel),
    .VPLL_ACTIVE(active), .VPLL_FAIL(fail), .STATE(st)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, then release just after an edge. The next tick is cycle 1.
  task automatic do_reset(input logic r, input logic l, input logic c);
    rst = 1'b1; req = r; lock = l; cfg = c;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; lock = 1'b1; cfg = 1'b1;
    tick(3);
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_hold: got %b want %b", obs, exp); end
  endtask

  task automatic test_lock_and_engage;
    do_reset(1'b1, 1'b0, 1'b0);
    tick(1);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_test_c1: got %b want %b", obs, exp); end
    tick(4); lock = 1'b1;                 // lock rises after cycle 5
    tick(2);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_sync_lat: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_stable: got %b want %b", obs, exp); end
    tick(7);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_stable_end: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b011_10_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_engage: got %b want %b", obs, exp); end
    tick(3);
    exp = 9'b011_10_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_engage_end: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b100_10_10_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_run: got %b want %b", obs, exp); end
    cfg = 1'b1; tick(1);
    exp = 9'b100_10_11_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_cfg_hi: got %b want %b", obs, exp); end
    cfg = 1'b0; tick(1);
    exp = 9'b100_10_10_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t1_cfg_lo: got %b want %b", obs, exp); end
  endtask

  task automatic test_lock_loss;              // continues from RUN
    lock = 1'b0;
    tick(2);
    exp = 9'b100_10_10_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t2_still_run: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t2_retry: got %b want %b", obs, exp); end
    tick(3);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t2_retry_end: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t2_retest: got %b want %b", obs, exp); end
  endtask

  task automatic test_timeout_fail;
    do_reset(1'b1, 1'b0, 1'b0);
    tick(20);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_test_w1: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_retry1: got %b want %b", obs, exp); end
    tick(4);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_test2: got %b want %b", obs, exp); end
    tick(19);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_test_w2: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_retry2: got %b want %b", obs, exp); end
    tick(3);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_retry2_end: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b111_00_00_0_1; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_fail: got %b want %b", obs, exp); end
    tick(5);
    exp = 9'b111_00_00_0_1; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_fail_hold: got %b want %b", obs, exp); end
    req = 1'b0; tick(1);
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_fail_off: got %b want %b", obs, exp); end
    // rc was cleared, so one more timeout retries instead of failing.
    req = 1'b1; tick(21);
    exp = 9'b110_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_rc_retry: got %b want %b", obs, exp); end
    tick(4);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t3_rc_cleared: got %b want %b", obs, exp); end
  endtask

  task automatic test_glitch;
    do_reset(1'b1, 1'b1, 1'b0);
    tick(3);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_stable: got %b want %b", obs, exp); end
    tick(4); lock = 1'b0;                 // synced lk is low at STABLE count 6
    tick(1); lock = 1'b1;
    tick(1);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_cnt6: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_back_test: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_restable: got %b want %b", obs, exp); end
    tick(7);
    exp = 9'b010_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_fresh_win: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b011_10_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_engage: got %b want %b", obs, exp); end
    tick(4);
    exp = 9'b100_10_10_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t4_run: got %b want %b", obs, exp); end
  endtask

  task automatic test_release;                // continues from RUN
    req = 1'b0; tick(1);
    exp = 9'b101_10_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t5_release: got %b want %b", obs, exp); end
    req = 1'b1;                               // ignored until the window ends
    tick(3);
    exp = 9'b101_10_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t5_release_end: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t5_off: got %b want %b", obs, exp); end
    tick(1);
    exp = 9'b001_01_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t5_rereq: got %b want %b", obs, exp); end
  endtask

  task automatic test_async_reset;
    do_reset(1'b1, 1'b1, 1'b1);
    tick(12);
    exp = 9'b011_10_01_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_engage: got %b want %b", obs, exp); end
    #2 rst = 1'b1; #1;
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_rst_engage: got %b want %b", obs, exp); end
    tick(2); rst = 1'b0; #1;
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_post_rst1: got %b want %b", obs, exp); end
    tick(15);
    exp = 9'b100_10_11_1_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_run: got %b want %b", obs, exp); end
    #2 rst = 1'b1; #1;
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_rst_run: got %b want %b", obs, exp); end
    tick(2); rst = 1'b0; #1;
    exp = 9'b000_00_00_0_0; n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL t6_post_rst2: got %b want %b", obs, exp); end
  endtask

  task automatic test_req_toggle;
    do_reset(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      req = ~req; tick(1);
      exp = req ? 9'b001_01_00_0_0 : 9'b000_00_00_0_0; n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL toggle_%0d: got %b want %b", i, obs, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; lock = 1'b0; cfg = 1'b0;
    test_reset;
    test_lock_and_engage;
    test_lock_loss;
    test_timeout_fail;
    test_glitch;
    test_release;
    test_async_reset;
    test_req_toggle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
